fetch_unit: RTL and testbench

- Instruction fetch stage directly downstream of the program counter.
- Takes the current PC and issues a req/ack read to instruction memory.
- Latches the returned word into an instruction register (IR) and offers it to decode with a valid/ready handshake.
- Pulses pc_inc back to the PC each time an instruction is captured; flush discards in-flight/held work when the PC is redirected by a branch or jump.

---
 rtl/fetch_unit_pkg.sv | 7 +
 rtl/fetch_unit.sv | 52 +++++
 tb/tb_fetch_unit.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared state encoding, width defaults and NOP word for the fetch stage
package fetch_unit_pkg;
  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 16;
  localparam logic [DATA_W_DEF-1:0] NOP = '0;
  typedef enum logic [1:0] {SETTLE, FETCH, HOLD} state_t;
endpackage

// File: rtl/fetch_unit.sv
// fetch_unit: issues req/ack reads at pc, holds the word in IR and hands it to decode via valid/ready
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc,
  output logic              pc_inc,
  input  logic              flush,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] ir,
  output logic [ADDR_W-1:0] ir_pc,
  output logic              ir_valid,
  input  logic              ir_ready,
  output logic [15:0]       fetch_count
);
  state_t state, state_n;
  logic capture, accept;
  // flush and rst squash the request, the capture and the accept in the same cycle
  always_comb begin
    mem_req = !rst && !flush && state == FETCH;
    mem_addr = pc;
    capture = mem_req && mem_ack;
    pc_inc = capture;
    accept = !rst && !flush && state == HOLD && ir_ready;
    state_n = flush ? SETTLE : state == SETTLE ? FETCH : capture ? HOLD : accept ? FETCH : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SETTLE;
      ir_valid <= 1'b0;
      ir <= '0;
      ir_pc <= '0;
      fetch_count <= '0;
    end else begin
      state <= state_n;
      if (capture) begin
        ir <= mem_rdata;
        ir_pc <= pc;
      end
      if (flush || accept) ir_valid <= 1'b0;
      else if (capture) ir_valid <= 1'b1;
      if (accept) fetch_count <= fetch_count + 16'd1;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scenario tasks with a capture scoreboard checked at every decode accept
module tb_fetch_unit;
  logic clk = 0, rst = 1, flush = 0, mem_ack = 0, ir_ready = 0;
  logic [15:0] pc = 0, mem_rdata = 0;
  logic pc_inc, mem_req, ir_valid;
  logic [15:0] mem_addr, ir, ir_pc, fetch_count;
  int n_chk = 0, n_fail = 0;
  logic [15:0] exp_cnt = 0;
  logic [31:0] sb[$];
  logic [31:0] e;

  fetch_unit dut (
    .clk(clk), .rst(rst), .pc(pc), .pc_inc(pc_inc), .flush(flush),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .ir(ir), .ir_pc(ir_pc), .ir_valid(ir_valid), .ir_ready(ir_ready), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // scoreboard: every accepted instruction must match the oldest captured one
  always @(negedge clk) begin
    if (rst) exp_cnt = 0;
    else if (ir_valid && ir_ready && !flush) begin
      n_chk++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL sb_accept: got pc=%h ir=%h, none expected", ir_pc, ir);
      end else begin
        e = sb.pop_front();
        if ({ir_pc, ir} !== e) begin
          n_fail++;
          $display("FAIL sb_accept: got pc=%h ir=%h, want pc=%h ir=%h", ir_pc, ir, e[31:16], e[15:0]);
        end
      end
      exp_cnt = exp_cnt + 16'd1;
    end
  end

  task automatic test_reset;
    rst = 1; ir_ready = 1;
    tick; tick;
    n_chk++;
    if ({mem_req, pc_inc, ir_valid, ir, ir_pc, fetch_count} !== 51'd0) begin
      n_fail++; $display("FAIL reset_vals: req=%b inc=%b v=%b ir=%h pc=%h cnt=%h, want all 0", mem_req, pc_inc, ir_valid, ir, ir_pc, fetch_count);
    end
    rst = 0; pc = 16'h0000;
    #1; n_chk++;
    if (mem_req !== 1'b0) begin n_fail++; $display("FAIL settle_req: got %b want 0", mem_req); end
    tick;
    mem_ack = 1; mem_rdata = 16'hA001; sb.push_back({16'h0000, 16'hA001});
    #1; n_chk++;
    if ({mem_req, mem_addr, pc_inc} !== {1'b1, 16'h0000, 1'b1}) begin
      n_fail++; $display("FAIL first_req: req=%b addr=%h inc=%b, want 1 0000 1", mem_req, mem_addr, pc_inc);
    end
    tick;
    mem_ack = 0;
    #1; n_chk++;
    if ({ir_valid, ir, ir_pc, mem_req, pc_inc} !== {1'b1, 16'hA001, 16'h0000, 2'b00}) begin
      n_fail++; $display("FAIL first_ir: v=%b ir=%h pc=%h req=%b inc=%b, want 1 a001 0000 0 0", ir_valid, ir, ir_pc, mem_req, pc_inc);
    end
    tick;
    n_chk++;
    if (fetch_count !== 16'd1 || exp_cnt !== 16'd1) begin n_fail++; $display("FAIL first_cnt: got %0d model %0d want 1", fetch_count, exp_cnt); end
  endtask

  task automatic test_wait;
    int pulses = 0;
    pc = 16'h0010; ir_ready = 1;
    for (int i = 0; i < 4; i++) begin
      mem_ack = (i == 3); mem_rdata = 16'h5A5A;
      if (i == 3) sb.push_back({16'h0010, 16'h5A5A});
      #1; n_chk++;
      if ({mem_req, mem_addr, pc_inc} !== {1'b1, 16'h0010, i == 3}) begin
        n_fail++; $display("FAIL wait_req[%0d]: req=%b addr=%h inc=%b", i, mem_req, mem_addr, pc_inc);
      end
      pulses += int'(pc_inc);
      tick;
    end
    mem_ack = 0;
    n_chk++;
    if (pulses != 1) begin n_fail++; $display("FAIL wait_pulses: got %0d want 1", pulses); end
    #1; n_chk++;
    if ({ir_valid, ir, mem_req} !== {1'b1, 16'h5A5A, 1'b0}) begin
      n_fail++; $display("FAIL wait_ir: v=%b ir=%h req=%b", ir_valid, ir, mem_req);
    end
    tick;
  endtask

  task automatic test_backpressure;
    pc = 16'h0020; ir_ready = 0; mem_ack = 1; mem_rdata = 16'h1234;
    sb.push_back({16'h0020, 16'h1234});
    #1; n_chk++;
    if (pc_inc !== 1'b1) begin n_fail++; $display("FAIL bp_capture_inc: got %b want 1", pc_inc); end
    tick;
    pc = 16'h0021; mem_rdata = 16'hFFFF;
    for (int i = 0; i < 5; i++) begin
      #1; n_chk++;
      if ({ir_valid, ir, ir_pc, mem_req, pc_inc} !== {1'b1, 16'h1234, 16'h0020, 2'b00}) begin
        n_fail++; $display("FAIL bp_hold[%0d]: v=%b ir=%h pc=%h req=%b inc=%b", i, ir_valid, ir, ir_pc, mem_req, pc_inc);
      end
      tick;
    end
    mem_ack = 0; ir_ready = 1;
    tick;
    n_chk++;
    if (fetch_count !== exp_cnt || fetch_count !== 16'd3) begin n_fail++; $display("FAIL bp_cnt: got %0d want 3", fetch_count); end
  endtask

  task automatic test_flush_fetch;
    pc = 16'h0030; mem_ack = 1; mem_rdata = 16'hDEAD; flush = 1; ir_ready = 0;
    #1; n_chk++;
    if ({pc_inc, mem_req} !== 2'b00) begin n_fail++; $display("FAIL ff_squash: inc=%b req=%b want 0 0", pc_inc, mem_req); end
    tick;
    flush = 0; mem_ack = 0; pc = 16'h0200;
    #1; n_chk++;
    if ({ir_valid, mem_req} !== 2'b00) begin n_fail++; $display("FAIL ff_settle: v=%b req=%b want 0 0", ir_valid, mem_req); end
    tick;
    #1; n_chk++;
    if ({mem_req, mem_addr} !== {1'b1, 16'h0200}) begin n_fail++; $display("FAIL ff_refetch: req=%b addr=%h want 1 0200", mem_req, mem_addr); end
    mem_ack = 1; mem_rdata = 16'h7777; sb.push_back({16'h0200, 16'h7777});
    tick;
    mem_ack = 0;
  endtask

  task automatic test_flush_hold;
    logic [15:0] cnt0 = fetch_count;
    #1; n_chk++;
    if ({ir_valid, ir} !== {1'b1, 16'h7777}) begin n_fail++; $display("FAIL fh_held: v=%b ir=%h want 1 7777", ir_valid, ir); end
    flush = 1; ir_ready = 1; pc = 16'h0300;
    sb.delete(0);
    #1; n_chk++;
    if ({mem_req, pc_inc} !== 2'b00) begin n_fail++; $display("FAIL fh_req: req=%b inc=%b want 0 0", mem_req, pc_inc); end
    tick;
    flush = 0; ir_ready = 0;
    #1; n_chk++;
    if (ir_valid !== 1'b0 || fetch_count !== cnt0) begin
      n_fail++; $display("FAIL fh_drop: v=%b cnt=%0d want 0 %0d", ir_valid, fetch_count, cnt0);
    end
    tick;
    n_chk++;
    if ({mem_req, mem_addr} !== {1'b1, 16'h0300}) begin n_fail++; $display("FAIL fh_refetch: req=%b addr=%h want 1 0300", mem_req, mem_addr); end
  endtask

  task automatic test_wrap;
    force dut.fetch_count = 16'hFFFE;
    #1 release dut.fetch_count;
    exp_cnt = 16'hFFFE; ir_ready = 1;
    for (int i = 0; i < 2; i++) begin
      pc = 16'hFFFF + 16'(i); mem_ack = 1; mem_rdata = 16'hC000 + 16'(i);
      sb.push_back({16'hFFFF + 16'(i), 16'hC000 + 16'(i)});
      tick;
      mem_ack = 0;
      tick;
    end
    n_chk++;
    if (fetch_count !== 16'h0000) begin n_fail++; $display("FAIL wrap_cnt: got %h want 0000", fetch_count); end
  endtask

  task automatic test_rst_mid;
    pc = 16'h0400; mem_ack = 1; mem_rdata = 16'hBEEF; ir_ready = 1; rst = 1;
    tick;
    rst = 0; mem_ack = 0;
    #1; n_chk++;
    if ({mem_req, pc_inc, ir_valid, ir, ir_pc, fetch_count} !== 51'd0) begin
      n_fail++; $display("FAIL rst_mid: req=%b inc=%b v=%b ir=%h pc=%h cnt=%h, want all 0", mem_req, pc_inc, ir_valid, ir, ir_pc, fetch_count);
    end
    tick;
    n_chk++;
    if ({mem_req, mem_addr} !== {1'b1, 16'h0400}) begin n_fail++; $display("FAIL rst_refetch: req=%b addr=%h want 1 0400", mem_req, mem_addr); end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset;
    test_wait;
    test_backpressure;
    test_flush_fetch;
    test_flush_hold;
    test_wrap;
    test_rst_mid;
    n_chk++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL sb_leftover: got %0d entries want 0", sb.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
